// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - request/response and SPI pin bundle for spi_master_ctrl
// Ports (signals):
//   start, tx_data, cs_hold, cs_release : requester -> controller
//   busy, done, rx_data                 : controller -> requester
//   SCK, MOSI, CS_n                     : controller -> SPI peripheral
//   MISO                                : SPI peripheral -> controller
// Modports: master = controller side, slave = requester/peripheral side.
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              cs_hold;
    logic              cs_release;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              SCK;
    logic              MOSI;
    logic              MISO;
    logic              CS_n;

    modport master (
        input  start, tx_data, cs_hold, cs_release, MISO,
        output busy, done, rx_data, SCK, MOSI, CS_n
    );

    modport slave (
        output start, tx_data, cs_hold, cs_release, MISO,
        input  busy, done, rx_data, SCK, MOSI, CS_n
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 single-CS byte master with programmable SCK divider
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_ctrl_if.master (start/tx_data/cs_hold/cs_release in,
//          busy/done/rx_data out, SCK/MOSI/CS_n out, MISO in)
// Parameters:
//   CLK_DIV : SCK half-period in clk cycles (1..255)
//   DATA_W  : bits per transfer (8)
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_ctrl_if.master     bus
);
    localparam int           BIT_W    = $clog2(DATA_W);
    localparam logic [7:0]   DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        TAIL     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [7:0]        r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_hold;
    logic              r_sck;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_start;
    logic              w_last_bit;
    logic              w_sck_next;
    logic              w_mosi_next;
    logic              w_cs_n_next;
    logic              w_busy_next;
    logic              w_done_next;

    // w_tick marks the last clk of the current SCK half-period.
    assign w_tick     = (r_cnt == DIV_LAST);
    assign w_start    = (r_state == IDLE) && bus.start;
    assign w_last_bit = (r_bit == BIT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (bus.start) w_state_next = SHIFT_LO;
            SHIFT_LO: if (w_tick)    w_state_next = SHIFT_HI;
            SHIFT_HI: if (w_tick)    w_state_next = w_last_bit ? TAIL : SHIFT_LO;
            TAIL:     if (w_tick)    w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered pin/handshake outputs.
    always_comb begin
        w_sck_next  = r_sck;
        w_mosi_next = r_mosi;
        w_cs_n_next = r_cs_n;
        w_busy_next = r_busy;
        w_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                // start takes priority over a coincident cs_release, so a held
                // CS_n stays low straight into the next byte.
                if (bus.start) begin
                    w_cs_n_next = 1'b0;
                    w_mosi_next = bus.tx_data[DATA_W-1];
                    w_sck_next  = 1'b0;
                    w_busy_next = 1'b1;
                end else if (bus.cs_release) begin
                    w_cs_n_next = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (w_tick) w_sck_next = 1'b1;
            end
            SHIFT_HI: begin
                if (w_tick) begin
                    w_sck_next = 1'b0;
                    if (!w_last_bit) w_mosi_next = r_tx[DATA_W-2];
                end
            end
            TAIL: begin
                if (w_tick) begin
                    w_done_next = 1'b1;
                    w_busy_next = 1'b0;
                    w_cs_n_next = ~r_hold;
                end
            end
            default: begin
                w_sck_next = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_hold    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_sck  <= w_sck_next;
            r_mosi <= w_mosi_next;
            r_cs_n <= w_cs_n_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;

            if (r_state == IDLE || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_tx   <= bus.tx_data;
                        r_hold <= bus.cs_hold;
                        r_bit  <= '0;
                        r_rx   <= '0;
                    end else if (bus.cs_release) begin
                        r_hold <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    // MISO is sampled on the same edge that raises SCK, i.e.
                    // before the slave reacts to that rise.
                    if (w_tick) r_rx <= {r_rx[DATA_W-2:0], bus.MISO};
                end
                SHIFT_HI: begin
                    if (w_tick && !w_last_bit) begin
                        r_bit <= r_bit + BIT_W'(1);
                        r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
                TAIL: begin
                    if (w_tick) r_rx_data <= r_rx;
                end
                default: begin
                    r_bit <= '0;
                end
            endcase
        end
    end

    assign bus.SCK     = r_sck;
    assign bus.MOSI    = r_mosi;
    assign bus.CS_n    = r_cs_n;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl at CLK_DIV 4 and 1
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATA_W(8)) if4();
    spi_master_ctrl_if #(.DATA_W(8)) if1();

    spi_master_ctrl #(.CLK_DIV(4), .DATA_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.master));
    spi_master_ctrl #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    // Loopback peripherals: MISO takes the current MOSI on each SCK rise.
    logic preset4 = 1'b0;
    logic preset1 = 1'b0;
    always @(posedge if4.SCK or posedge preset4)
        if (preset4) if4.MISO <= 1'b1; else if4.MISO <= if4.MOSI;
    always @(posedge if1.SCK or posedge preset1)
        if (preset1) if1.MISO <= 1'b1; else if1.MISO <= if1.MOSI;

    logic [7:0] cap4 = 8'h00;
    int         rises4 = 0;
    always @(posedge if4.SCK) begin
        cap4   <= {cap4[6:0], if4.MOSI};
        rises4 <= rises4 + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] sb4[$];
    logic [7:0] sb1[$];
    logic [7:0] e4, e1;

    always @(negedge clk) begin
        if (if4.done === 1'b1) begin
            if (sb4.size() == 0) check("done4_unexpected", 1, 0);
            else begin
                e4 = sb4.pop_front();
                check("rx4", {24'h0, if4.rx_data}, {24'h0, e4});
            end
        end
        if (if1.done === 1'b1) begin
            if (sb1.size() == 0) check("done1_unexpected", 1, 0);
            else begin
                e1 = sb1.pop_front();
                check("rx1", {24'h0, if1.rx_data}, {24'h0, e1});
            end
        end
    end

    task automatic pulse_preset4();
        preset4 = 1'b1; #1; preset4 = 1'b0;
    endtask

    task automatic xfer4(input logic [7:0] tx, input logic hold, input logic rel, input logic poke,
                         input logic [7:0] exp, output int lat, output int cs_hi, output logic cs_end);
        logic [7:0] t;
        t = tx;
        @(negedge clk);
        if4.tx_data    = tx;
        if4.cs_hold    = hold;
        if4.cs_release = rel;
        if4.start      = 1'b1;
        sb4.push_back(exp);
        @(posedge clk); #1;
        if4.start      = 1'b0;
        if4.cs_release = 1'b0;
        check("edge0_cs_n", {31'h0, if4.CS_n}, 0);
        check("edge0_busy", {31'h0, if4.busy}, 1);
        check("edge0_mosi", {31'h0, if4.MOSI}, {31'h0, t[7]});
        lat = -1; cs_hi = 0; cs_end = 1'bx;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (poke) begin
                if4.start   = (n == 20 || n == 67);
                if4.tx_data = 8'h00;
            end
            if (if4.done === 1'b1) begin
                lat = n; cs_end = if4.CS_n;
                break;
            end
            if (if4.CS_n !== 1'b0) cs_hi++;
        end
        if4.start = 1'b0;
    endtask

    task automatic xfer1(input logic [7:0] tx, input logic [7:0] exp, output int lat, output int sck_bad);
        @(negedge clk);
        if1.tx_data = tx; if1.cs_hold = 1'b0; if1.cs_release = 1'b0; if1.start = 1'b1;
        sb1.push_back(exp);
        @(posedge clk); #1;
        if1.start = 1'b0;
        lat = -1; sck_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n <= 16 && if1.SCK !== n[0]) sck_bad++;
            if (if1.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    int   lat, cs_hi, r0, sck_bad;
    logic cs_end;

    initial begin
        if4.start = 0; if4.tx_data = 0; if4.cs_hold = 0; if4.cs_release = 0;
        if1.start = 0; if1.tx_data = 0; if1.cs_hold = 0; if1.cs_release = 0;
        preset4 = 1'b1; preset1 = 1'b1; #1; preset4 = 1'b0; preset1 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sck",  {31'h0, if4.SCK},  0);
        check("rst_cs_n", {31'h0, if4.CS_n}, 1);
        check("rst_mosi", {31'h0, if4.MOSI}, 0);
        check("rst_busy", {31'h0, if4.busy}, 0);
        check("rst_done", {31'h0, if4.done}, 0);
        check("rst_rx",   {24'h0, if4.rx_data}, 0);
        check("rst1_cs_n", {31'h0, if1.CS_n}, 1);
        rst = 1'b0;

        // Reset in the middle of bit 3 (SCK high, MOSI=1)
        @(negedge clk);
        if4.tx_data = 8'h5A; if4.cs_hold = 1'b0; if4.start = 1'b1;
        @(posedge clk); #1; if4.start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        check("pre_rst_sck", {31'h0, if4.SCK}, 1);
        rst = 1'b1; #1;
        check("mid_rst_sck",  {31'h0, if4.SCK},  0);
        check("mid_rst_cs_n", {31'h0, if4.CS_n}, 1);
        check("mid_rst_mosi", {31'h0, if4.MOSI}, 0);
        check("mid_rst_busy", {31'h0, if4.busy}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        pulse_preset4();
        xfer4(8'h00, 1'b0, 1'b0, 1'b0, 8'h80, lat, cs_hi, cs_end);
        check("after_rst_lat", lat, 68);

        // Single transfer 0xA5
        pulse_preset4();
        r0 = rises4;
        xfer4(8'hA5, 1'b0, 1'b0, 1'b0, 8'hD2, lat, cs_hi, cs_end);
        check("single_lat",    lat, 68);
        check("single_rises",  rises4 - r0, 8);
        check("single_mosi",   {24'h0, cap4}, 32'hA5);
        check("single_cs_end", {31'h0, cs_end}, 1);
        check("single_busy",   {31'h0, if4.busy}, 0);
        check("single_cs_hi",  cs_hi, 0);

        // Chained frame under one CS_n
        pulse_preset4();
        xfer4(8'hA5, 1'b1, 1'b0, 1'b0, 8'hD2, lat, cs_hi, cs_end);
        check("chain1_cs_end", {31'h0, cs_end}, 0);
        xfer4(8'h3C, 1'b1, 1'b0, 1'b0, 8'h9E, lat, cs_hi, cs_end);
        check("chain2_lat",    lat, 68);
        check("chain2_cs_hi",  cs_hi, 0);
        check("chain2_cs_end", {31'h0, cs_end}, 0);
        @(negedge clk);
        check("held_idle_cs_n", {31'h0, if4.CS_n}, 0);
        if4.cs_release = 1'b1;
        @(posedge clk); #1;
        if4.cs_release = 1'b0;
        check("release_cs_n", {31'h0, if4.CS_n}, 1);

        // Starts while busy and on the done cycle are ignored
        pulse_preset4();
        r0 = rises4;
        xfer4(8'hA5, 1'b0, 1'b0, 1'b1, 8'hD2, lat, cs_hi, cs_end);
        check("poke_lat",   lat, 68);
        check("poke_rises", rises4 - r0, 8);
        check("poke_mosi",  {24'h0, cap4}, 32'hA5);
        repeat (4) begin
            @(posedge clk); #1;
            check("poke_idle_busy", {31'h0, if4.busy}, 0);
        end

        // start and cs_release together with CS held
        pulse_preset4();
        xfer4(8'h11, 1'b1, 1'b0, 1'b0, 8'h88, lat, cs_hi, cs_end);
        check("coinc1_cs_end", {31'h0, cs_end}, 0);
        xfer4(8'h22, 1'b0, 1'b1, 1'b0, 8'h91, lat, cs_hi, cs_end);
        check("coinc2_cs_hi",  cs_hi, 0);
        check("coinc2_cs_end", {31'h0, cs_end}, 1);

        // CLK_DIV = 1
        preset1 = 1'b1; #1; preset1 = 1'b0;
        xfer1(8'hFF, 8'hFF, lat, sck_bad);
        check("d1_lat_a", lat, 17);
        check("d1_sck_a", sck_bad, 0);
        xfer1(8'hFF, 8'hFF, lat, sck_bad);
        check("d1_lat_b", lat, 17);
        check("d1_sck_b", sck_bad, 0);

        repeat (3) @(posedge clk);
        check("sb4_empty", sb4.size(), 0);
        check("sb1_empty", sb1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-chip-select SPI mode-0 master that sequences 8-bit full-duplex transfers onto the CEP SPI pins (SCK/MOSI/MISO/CS_n) for a peripheral such as the cosim SPI loopback model. It accepts one byte per start request and generates SCK from the system clock through a programmable divider. It shifts MOSI out MSB-first while sampling MISO, and returns the received byte with a one-cycle done pulse. An optional chip-select hold lets the requester chain multi-byte frames under one CS_n assertion.

## Interface
- CLK_DIV, 4: SCK half-period in clk cycles; legal range 1..255.
- DATA_W, 8: bits per transfer; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  8  byte to send; captured together with start.
- cs_hold  input  1  captured with start; 1 keeps CS_n low after the transfer ends.
- cs_release  input  1  pulse; in IDLE with CS held, releases CS_n.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- rx_data  output  8  received byte; valid from the done cycle until the next done.
- SCK  output  1  SPI clock; idle low (CPOL=0).
- MOSI  output  1  serial data out, MSB first.
- MISO  input  1  serial data in.
- CS_n  output  1  active-low chip select.

## Operation
- States: IDLE, SHIFT_LO (SCK low), SHIFT_HI (SCK high), TAIL.
- Registers: half-period counter (8 bits), bit counter (0..7), tx shift register, rx shift register, held-CS flag.
- IDLE + start=1:
  - Capture tx_data and cs_hold.
  - Drive CS_n=0, MOSI=tx_data[7], SCK=0.
  - Assert busy, then go to SHIFT_LO.
- While busy, start is ignored.
- SHIFT_LO: after CLK_DIV cycles, drive SCK to 1 and shift MISO into the rx register LSB in that same clk edge. The rx register therefore holds the MISO value from before the slave's own SCK-rise update. Then go to SHIFT_HI.
- SHIFT_HI: after CLK_DIV cycles, drive SCK to 0.
  - If bit count < 7: increment it, drive MOSI with the next bit, go to SHIFT_LO.
  - Otherwise: go to TAIL with MOSI unchanged.
- TAIL: after CLK_DIV cycles:
  - rx_data is loaded from the rx register; done is pulsed; busy drops.
  - CS_n goes to 1 unless the captured cs_hold is set.
  - Return to IDLE.
- Held CS:
  - In IDLE with CS_n=0, a new start keeps CS_n at 0 with no glitch.
  - cs_release=1 in IDLE drives CS_n=1 on the next edge.
  - cs_release outside IDLE is ignored.
  - If start and cs_release coincide in IDLE, start wins and cs_release is dropped.
- rst (any time, including mid-transfer): state=IDLE, SCK=0, CS_n=1, MOSI=0, busy=0, done=0, rx_data=0, counters=0. A partial byte is discarded and done is not emitted.

## Timing
- Let D = CLK_DIV. The start is sampled at edge 0.
- Edge 0: CS_n, MOSI (bit 7) and busy become valid.
- SCK rise k (k=0..7): edge (2k+1)·D.
- SCK fall k: edge (2k+2)·D. MOSI changes on falls 0..6.
- done, busy=0, rx_data update and CS_n release: edge 17·D. For D=4 this is edge 68.
- Back-to-back: start on the done cycle is ignored. Start one cycle later is accepted, giving a minimum period of 17·D+1 cycles.
- SCK duty is exactly D high / D low.
- CS_n-to-first-SCK setup and last-SCK-to-CS_n hold are each D cycles.

## Test plan
- Reset mid-transfer: assert rst at bit 3 -> SCK=0, CS_n=1, MOSI=0, busy=0 immediately; no done pulse; a following transfer of 0x00 completes normally.
- Single transfer to the loopback model (MISO initial 1), D=4, tx 0xA5, cs_hold=0:
  - rx_data=0xD2 (MISO lags one bit).
  - done at edge 68; exactly 8 SCK rises.
  - MOSI bit sequence 1,0,1,0,0,1,0,1; CS_n high at edge 68.
- Chained frame: the same flow, but cs_hold=1, then start 0x3C:
  - CS_n stays 0 throughout.
  - Second rx_data=0x9E.
  - cs_release -> CS_n=1 one cycle later.
- start asserted while busy, and on the done cycle -> ignored; tx register is unchanged; no extra done pulse.
- D=1, tx 0xFF -> SCK toggles every cycle, done at edge 17, rx_data=0xFF after a prior 0xFF.
- start and cs_release in the same IDLE cycle with CS held -> transfer starts and CS_n stays 0.
